// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the memory stage and its access FSM.
//   ADDR_W     - data-memory word-address width (same as PC width)
//   REG_ZERO   - hard-wired zero register, never forwarded
//   REG_STATUS - register that receives the overflow status
//   mem_state_e- memory-access FSM states
package pipe_pkg;

  localparam int ADDR_W = 12;
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: ready/valid bus between the memory stage and data memory.
//   dmem_req   - request outstanding (master)
//   dmem_we    - 1 = store, 0 = load (master)
//   dmem_addr  - word address (master)
//   dmem_wdata - store data (master)
//   dmem_ready - access complete this cycle (slave)
//   dmem_rdata - load data, valid together with dmem_ready (slave)
// Request fields are held stable by the master while dmem_req is high.
interface mem_stage_if #(
  parameter int ADDR_W = 12
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );

endinterface

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: owns the data-memory handshake for the memory stage.
//   clock, reset - rising-edge clock, synchronous active-low reset
//   i_valid      - X/M entry holds a real instruction
//   i_mem        - X/M entry is a load or store
//   i_oob        - X/M address is outside data memory
//   i_ready      - memory completion
//   o_req        - request outstanding (state == ACCESS)
//   o_stall      - freeze X/M and everything upstream
//   o_retire     - X/M entry leaves for the M/W register at the next edge
module mem_access_fsm
  import pipe_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_valid,
  input  logic i_mem,
  input  logic i_oob,
  input  logic i_ready,
  output logic o_req,
  output logic o_stall,
  output logic o_retire
);

  mem_state_e r_state;
  mem_state_e w_next;
  logic       w_issue;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    o_req    = 1'b0;
    o_stall  = 1'b0;
    o_retire = 1'b0;
    w_issue  = i_valid & i_mem & ~i_oob;
    case (r_state)
      IDLE: begin
        // A fresh in-range access holds X/M for one cycle while the
        // request is launched; anything else (including out-of-range
        // accesses) retires straight away. dmem_ready is ignored here.
        if (w_issue) begin
          w_next  = ACCESS;
          o_stall = 1'b1;
        end else begin
          o_retire = i_valid;
        end
      end
      ACCESS: begin
        o_req = 1'b1;
        if (i_ready) begin
          w_next   = IDLE;
          o_retire = 1'b1;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
//   clock, reset          - rising-edge clock, synchronous active-low reset
//   x_valid..x_sw         - execute results captured into the X/M register
//   stall_m               - freeze X and everything upstream this cycle
//   dmem                  - data-memory bus (master side)
//   renOmem/readOmem/dataOmem - forwarding of the X/M result to execute
//   wb_valid/wb_ren/wb_rd/wb_data - M/W register
//   mem_oob               - pulses with the writeback of an out-of-range access
module mem_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_valid,
  input  logic [31:0]       Oout,
  input  logic [31:0]       Bout,
  input  logic [4:0]        rd_outX,
  input  logic              x_ren,
  input  logic              x_lw,
  input  logic              x_sw,
  output logic              stall_m,
  mem_stage_if.master       dmem,
  output logic              renOmem,
  output logic [4:0]        readOmem,
  output logic [31:0]       dataOmem,
  output logic              wb_valid,
  output logic              wb_ren,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              mem_oob
);

  logic        r_valid, r_ren, r_lw, r_sw;
  logic [31:0] r_oout, r_bout;
  logic [4:0]  r_rd;

  logic        r_wb_valid, r_wb_ren, r_mem_oob;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_req, w_stall, w_retire, w_oob, w_mem;
  logic [31:0] w_wb_data;

  assign w_mem = r_lw | r_sw;
  assign w_oob = |r_oout[31:ADDR_W];

  mem_access_fsm u_fsm (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (r_valid),
    .i_mem    (w_mem),
    .i_oob    (w_oob),
    .i_ready  (dmem.dmem_ready),
    .o_req    (w_req),
    .o_stall  (w_stall),
    .o_retire (w_retire)
  );

  // X/M register: captures execute results unless the stage is stalled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ren   <= 1'b0;
      r_lw    <= 1'b0;
      r_sw    <= 1'b0;
      r_oout  <= 32'd0;
      r_bout  <= 32'd0;
      r_rd    <= 5'd0;
    end else if (!w_stall) begin
      r_valid <= x_valid;
      r_ren   <= x_ren;
      r_lw    <= x_lw;
      r_sw    <= x_sw;
      r_oout  <= Oout;
      r_bout  <= Bout;
      r_rd    <= rd_outX;
    end
  end

  // Writeback data: an out-of-range load yields zero.
  always_comb begin
    w_wb_data = r_oout;
    if (r_lw) begin
      w_wb_data = w_oob ? 32'd0 : dmem.dmem_rdata;
    end else begin
      w_wb_data = r_oout;
    end
  end

  // M/W register: loads on retire, otherwise becomes a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_ren   <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_mem_oob  <= 1'b0;
    end else if (w_retire) begin
      r_wb_valid <= 1'b1;
      r_wb_ren   <= r_ren & ~r_sw;
      r_wb_rd    <= r_rd;
      r_wb_data  <= w_wb_data;
      r_mem_oob  <= w_mem & w_oob;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_ren   <= 1'b0;
      r_mem_oob  <= 1'b0;
    end
  end

  assign stall_m         = w_stall;
  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = r_sw;
  assign dmem.dmem_addr  = r_oout[ADDR_W-1:0];
  assign dmem.dmem_wdata = r_bout;

  // Loads are never forwarded from here; decode handles load-use hazards.
  assign renOmem  = r_valid & r_ren & ~r_lw & (r_rd != REG_ZERO);
  assign readOmem = r_rd;
  assign dataOmem = r_oout;

  assign wb_valid = r_wb_valid;
  assign wb_ren   = r_wb_ren;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign mem_oob  = r_mem_oob;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, directly downstream of the execute stage. It captures the execute results into the X/M register, performs load/store accesses against data memory over a ready/valid handshake, and stalls upstream while an access is outstanding. It registers results into the M/W register for writeback. It drives the `renOmem`/`readOmem`/`dataOmem` forwarding bus back into execute.

## Interface
- `ADDR_W`, default 12: data-memory word-address width (same as PC width).
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-low.
- `x_valid` in 1: execute presents a real instruction (0 = bubble).
- `Oout` in 32: execute result; memory word address for lw/sw.
- `Bout` in 32: forwarded rt value; store data.
- `rd_outX` in 5: destination register (already 30 on overflow).
- `x_ren` in 1: instruction writes a register.
- `x_lw`, `x_sw` in 1 each: load / store (mutually exclusive).
- `stall_m` out 1: freeze X and everything upstream this cycle.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out ADDR_W; `dmem_wdata` out 32: memory request, held stable while `dmem_req`=1.
- `dmem_ready` in 1; `dmem_rdata` in 32: completion; `dmem_rdata` is valid in the same cycle as `dmem_ready` for reads.
- `renOmem` out 1; `readOmem` out 5; `dataOmem` out 32: forwarding to execute.
- `wb_valid`, `wb_ren` out 1; `wb_rd` out 5; `wb_data` out 32: M/W register.
- `mem_oob` out 1: one-cycle pulse, access address out of range.

## Operation
- X/M register captures `x_valid`, `Oout`, `Bout`, `rd_outX`, `x_ren`, `x_lw`, `x_sw` on every edge where `stall_m`=0. It holds when `stall_m`=1.
- FSM states are IDLE and ACCESS.
  - IDLE to ACCESS: captured instruction is a valid lw/sw with in-range address.
  - ACCESS to IDLE: on the edge where `dmem_ready`=1.
- `dmem_req` = (state==ACCESS). `dmem_we` = m_sw. `dmem_addr` = m_Oout[ADDR_W-1:0]. `dmem_wdata` = m_Bout.
- `stall_m` = (state==ACCESS) & ~`dmem_ready`, or (state==IDLE) & mem op just captured. Upstream therefore cannot overwrite the X/M register until completion.
- Out of range means m_Oout[31:ADDR_W] ≠ 0. No request is issued. A store is dropped. A load writes 0. `mem_oob` pulses for one cycle, and the instruction retires with no stall.
- M/W register loads when the instruction in X/M retires:
  - non-memory instructions retire immediately;
  - memory instructions retire on `dmem_ready`.
- M/W register contents: `wb_data` = load ? `dmem_rdata` : m_Oout. `wb_ren` = m_ren & ~m_sw. `wb_valid` is set for the retiring cycle and cleared otherwise (bubble).
- Forwarding:
  - `renOmem` = m_valid & m_ren & ~m_lw & (m_rd ≠ 0).
  - `readOmem` = m_rd; `dataOmem` = m_Oout.
  - Load results are never forwarded from M. Load-use hazards are the decode stage's job.

## Timing
- On reset: state IDLE; all valids 0. `dmem_req`, `dmem_we`, `stall_m`, `renOmem`, `wb_valid`, `wb_ren`, `mem_oob` = 0. All data/address outputs = 0.
- Non-memory op: captured at edge N, visible on `wb_*` after edge N+1.
- Memory op: captured at edge N; `dmem_req` high from N to completion. With `dmem_ready` high in cycle k, `wb_*` is valid after edge k. Zero-wait memory gives 2-cycle latency and one stall cycle.
- `dmem_req` never drops before `dmem_ready`. Address, data and we do not change while requested.
- `dmem_ready` while state IDLE is ignored.
- Reset asserted during ACCESS: `dmem_req` low after that edge; the in-flight access is abandoned; no writeback.
- Back-to-back lw/sw: the second is captured on the completion edge of the first and issues its request the next cycle.
- Bubble (`x_valid`=0) enters as an invalid entry: no request, no forwarding, `wb_valid`=0.

## Structure
- Shared package `pipe_pkg`: FSM state enum (IDLE, ACCESS), `REG_ZERO`=5'd0, `REG_STATUS`=5'd30, `ADDR_W`=12.
- One sub-module, `mem_access_fsm`. It owns the state register and the handshake, and generates `dmem_req`/`stall_m`/retire. The X/M and M/W registers and the forwarding logic live in `mem_stage`.

## Test plan
- add result 0x0000_0005 to rd=3, `x_ren`=1 → `renOmem`=1, `readOmem`=3, `dataOmem`=5 next cycle; `wb_data`=5 one cycle later; `stall_m` never high.
- sw `Oout`=0x10, `Bout`=0xDEAD_BEEF, `dmem_ready` after 3 cycles → `dmem_req`/`dmem_we` held 3 cycles with `dmem_addr`=0x010; `stall_m` high until ready; `wb_ren`=0.
- lw `Oout`=0x20, `dmem_rdata`=0x1234 with immediate ready → `wb_data`=0x1234, `wb_rd` correct; `renOmem`=0 throughout.
- Write to rd=0 → `renOmem`=0. `rd_outX`=30 overflow result → forwarded with `readOmem`=30.
- lw `Oout`=0x0000_1000 (out of range) → no `dmem_req`, `mem_oob` pulse, `wb_data`=0.
- Reset low during ACCESS → `dmem_req`=0, `wb_valid`=0 next cycle; the following add retires normally.
